// File: rtl/ccff_chain_loader.sv
// Source end of the ccff_head/ccff_tail configuration chain: serializes bitstream words MSB first
// onto ccff_head for exactly CHAIN_LEN shifts. Define CCFF_READBACK_EN to deserialize ccff_tail into rb_data.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 11,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int BL_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [BL_W-1:0]   bits_left_q, bits_left_d;
  logic [WB_W-1:0]   word_bits_q, word_bits_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              head_hold_q, head_hold_d;
  logic              shift;
  logic              accept;
  logic              last_shift;

  // bits_left counts bits not yet shifted into the chain, including those still in shreg.
  // A new word is wanted only when shreg is about to drain and the chain still needs more.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state_q;
    bits_left_d = bits_left_q;
    word_bits_d = word_bits_q;
    shreg_d     = shreg_q;
    head_hold_d = head_hold_q;

    shift      = (state_q == ST_LOAD) && (word_bits_q != '0);
    s_ready    = (state_q == ST_LOAD) && (word_bits_q <= WB_W'(1)) &&
                 (32'(bits_left_q) > 32'(word_bits_q));
    accept     = s_valid && s_ready;
    last_shift = shift && (bits_left_q == BL_W'(1));

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          bits_left_d = BL_W'(CHAIN_LEN);
          word_bits_d = '0;
        end
      end
      ST_LOAD: begin
        if (shift) begin
          bits_left_d = bits_left_q - BL_W'(1);
          head_hold_d = shreg_q[WORD_W-1];
          shreg_d     = shreg_q << 1;
          word_bits_d = word_bits_q - WB_W'(1);
        end
        // The final word is trimmed here, so its unused LSBs are never shifted.
        if (accept) begin
          shreg_d     = s_data;
          word_bits_d = (32'(bits_left_d) < WORD_W) ? WB_W'(bits_left_d) : WB_W'(WORD_W);
        end
        if (last_shift) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    // NOTE: the datapath registers are reset along with the FSM so every output reads 0 out of reset.
    if (!prog_reset_n) begin
      state_q     <= ST_IDLE;
      bits_left_q <= '0;
      word_bits_q <= '0;
      shreg_q     <= '0;
      head_hold_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      word_bits_q <= word_bits_d;
      shreg_q     <= shreg_d;
      head_hold_q <= head_hold_d;
    end
  end

  // During a stall the register is empty, so the head holds the last shifted bit.
  assign ccff_head   = (word_bits_q != '0) ? shreg_q[WORD_W-1] : head_hold_q;
  assign ccff_clk_en = shift;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] des_q;
  logic [WB_W-1:0]   rb_cnt_q;
  logic [WORD_W-1:0] des_nxt;
  logic [WB_W-1:0]   rb_cnt_nxt;

  always_comb begin
    des_nxt    = {des_q[WORD_W-2:0], ccff_tail};
    rb_cnt_nxt = rb_cnt_q + WB_W'(1);
  end

  // The tail is sampled on the same edges that shift the chain; a trailing partial word is
  // left-justified and emitted together with done.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      des_q    <= '0;
      rb_cnt_q <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (shift) begin
        des_q <= des_nxt;
        if (rb_cnt_nxt == WB_W'(WORD_W)) begin
          rb_data  <= des_nxt;
          rb_valid <= 1'b1;
          rb_cnt_q <= '0;
        end else if (last_shift) begin
          rb_data  <= des_nxt << (WORD_W - int'(rb_cnt_nxt));
          rb_valid <= 1'b1;
          rb_cnt_q <= '0;
        end else begin
          rb_cnt_q <= rb_cnt_nxt;
        end
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign rb_data     = '0;
  assign rb_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench for ccff_chain_loader (CHAIN_LEN=10, WORD_W=4): vector table, corner-case
// sequences and randomized loads against a behavioural chain and bitstream model.
module tb_ccff_chain_loader;

  localparam int CL = 10;
  localparam int WW = 4;
  localparam int NW = (CL + WW - 1) / WW;

  logic          prog_clk = 1'b0;
  logic          prog_reset_n = 1'b0;
  logic          start = 1'b0;
  logic [WW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          ccff_head;
  logic          ccff_clk_en;
  logic          ccff_tail;
  logic          busy;
  logic          done;
  logic [WW-1:0] rb_data;
  logic          rb_valid;

  int errors = 0;
  int checks = 0;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk    (prog_clk),
    .prog_reset_n(prog_reset_n),
    .start       (start),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .ccff_head   (ccff_head),
    .ccff_clk_en (ccff_clk_en),
    .ccff_tail   (ccff_tail),
    .busy        (busy),
    .done        (done),
    .rb_data     (rb_data),
    .rb_valid    (rb_valid)
  );

  always #5 prog_clk = ~prog_clk;

  // Behavioural chain: ccff_head enters bit 0, bit CL-1 is the tail-most flop.
  logic          chain_load = 1'b0;
  logic [CL-1:0] chain_init = '0;
  logic [CL-1:0] chain;
  always @(posedge prog_clk) begin
    if (chain_load)       chain <= chain_init;
    else if (ccff_clk_en) chain <= {chain[CL-2:0], ccff_head};
  end
  assign ccff_tail = chain[CL-1];

  logic [WW-1:0] rb_q[$];
  logic          rb_done_q[$];
  always @(negedge prog_clk) begin
    if (rb_valid) begin
      rb_q.push_back(rb_data);
      rb_done_q.push_back(done);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the chain receives the concatenated words MSB first, cut to CL bits.
  function automatic logic [CL-1:0] ref_bits(input logic [NW*WW-1:0] words);
    return words[NW*WW-1 -: CL];
  endfunction

  // Reference readback: previous contents, tail-most first, packed left-justified into words.
  function automatic logic [NW*WW-1:0] ref_rb(input logic [CL-1:0] snap);
    logic [NW*WW-1:0] s;
    s = '0;
    for (int i = 0; i < CL; i++) s[NW*WW-1-i] = snap[CL-1-i];
    return s;
  endfunction

  task automatic run_load(input logic [NW*WW-1:0] words, input int gap, input int restart_at,
                          output logic [CL-1:0] bits, output int hs, output int en_cnt,
                          output int stall, output int done_lat, output int late_ready,
                          output int busy_bad);
    int  last_en;
    int  first_en;
    int  gap_left;
    int  wi;
    bit  finished;
    bits = '0; hs = 0; en_cnt = 0; stall = 0; done_lat = -1; late_ready = 0; busy_bad = 0;
    last_en = -100; first_en = -1; gap_left = gap; wi = 0; finished = 0;
    @(negedge prog_clk); start = 1'b1;
    @(negedge prog_clk); start = 1'b0;
    for (int cyc = 0; cyc < 80 && !finished; cyc++) begin
      if (!busy) busy_bad++;
      if (ccff_clk_en) begin
        if (en_cnt < CL) bits[CL-1-en_cnt] = ccff_head;
        en_cnt++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end else if (first_en >= 0 && !done) begin
        stall++;
      end
      if (done) begin
        done_lat = cyc - last_en;
        finished = 1;
      end
      if (hs >= NW && s_ready) late_ready++;
      start = (cyc == restart_at);
      if (hs == 1 && s_ready && gap_left > 0) begin
        s_valid = 1'b0;
        gap_left--;
      end else begin
        s_valid = 1'b1;
        s_data  = (wi < NW) ? words[(NW-wi)*WW-1 -: WW] : 4'hF;
      end
      if (s_valid && s_ready) begin
        hs++;
        wi++;
      end
      @(negedge prog_clk);
    end
    s_valid = 1'b0;
    start   = 1'b0;
  endtask

  typedef struct {
    logic [NW*WW-1:0] words;
    int               gap;
    int               restart;
    logic [CL-1:0]    exp_bits;
    int               exp_stall;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [CL-1:0]    bits;
    logic [CL-1:0]    snap;
    logic [NW*WW-1:0] words;
    logic [NW*WW-1:0] exp_rb;
    int hs, en_cnt, stall, done_lat, late_ready, busy_bad, base, cnt, en;

    vecs[0] = '{words: 12'hA5C, gap: 0, restart: -1, exp_bits: 10'b1010010111, exp_stall: 0};
    vecs[1] = '{words: 12'hA5C, gap: 3, restart: 4,  exp_bits: 10'b1010010111, exp_stall: 3};
    vecs[2] = '{words: 12'hF03, gap: 1, restart: -1, exp_bits: 10'b1111000000, exp_stall: 1};
    vecs[3] = '{words: 12'h96F, gap: 2, restart: 2,  exp_bits: 10'b1001011011, exp_stall: 2};

    // Reset state
    repeat (2) @(negedge prog_clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset s_ready", s_ready, 0);
    check("reset clk_en", ccff_clk_en, 0);
    check("reset head", ccff_head, 0);
    check("reset rb_valid", rb_valid, 0);
    check("reset rb_data", rb_data, 0);
    prog_reset_n = 1'b1;
    chain_load = 1'b1; chain_init = '0;
    @(negedge prog_clk); chain_load = 1'b0;

    // s_valid in IDLE is ignored
    s_valid = 1'b1; s_data = 4'h9;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge prog_clk);
      if (s_ready || busy || ccff_clk_en) cnt++;
    end
    check("idle s_valid ignored", cnt, 0);
    s_valid = 1'b0;

    // Vector table
    for (int v = 0; v < 4; v++) begin
      run_load(vecs[v].words, vecs[v].gap, vecs[v].restart, bits, hs, en_cnt, stall, done_lat,
               late_ready, busy_bad);
      check($sformatf("vec%0d bits", v), bits, vecs[v].exp_bits);
      check($sformatf("vec%0d handshakes", v), hs, NW);
      check($sformatf("vec%0d clk_en count", v), en_cnt, CL);
      check($sformatf("vec%0d stall cycles", v), stall, vecs[v].exp_stall);
      check($sformatf("vec%0d done latency", v), done_lat, 1);
      check($sformatf("vec%0d late s_ready", v), late_ready, 0);
      check($sformatf("vec%0d busy during load", v), busy_bad, 0);
      check($sformatf("vec%0d idle after", v), {busy, done}, 2'b00);
      repeat (2) @(negedge prog_clk);
    end

    // Reset mid-load after 5 shifted bits
    start = 1'b1; @(negedge prog_clk); start = 1'b0;
    s_valid = 1'b1; s_data = 4'hA;
    en = 0;
    for (int cyc = 0; cyc < 40 && en < 5; cyc++) begin
      if (ccff_clk_en) en++;
      if (en < 5) @(negedge prog_clk);
    end
    check("midload reached 5 bits", en, 5);
    @(posedge prog_clk); #2;
    prog_reset_n = 1'b0;
    #1;
    check("async reset busy", busy, 0);
    check("async reset clk_en", ccff_clk_en, 0);
    check("async reset s_ready", s_ready, 0);
    check("async reset head", ccff_head, 0);
    s_valid = 1'b0;
    cnt = 0;
    @(negedge prog_clk); prog_reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge prog_clk);
      if (done || busy) cnt++;
    end
    check("no done after reset", cnt, 0);
    run_load(vecs[0].words, 0, -1, bits, hs, en_cnt, stall, done_lat, late_ready, busy_bad);
    check("post-reset bits", bits, vecs[0].exp_bits);
    check("post-reset clk_en count", en_cnt, CL);
    check("post-reset done latency", done_lat, 1);

    // Readback against a preloaded chain
    @(negedge prog_clk);
    chain_load = 1'b1; chain_init = 10'b1100110011;
    @(negedge prog_clk); chain_load = 1'b0;
    base = rb_q.size();
    run_load(12'hA5C, 0, -1, bits, hs, en_cnt, stall, done_lat, late_ready, busy_bad);
    check("rb chain new contents", chain, 10'b1010010111);
`ifdef CCFF_READBACK_EN
    check("rb word count", rb_q.size() - base, NW);
    if (rb_q.size() - base == NW) begin
      for (int k = 0; k < NW; k++) begin
        check($sformatf("rb word%0d", k), rb_q[base+k], 4'hC);
        check($sformatf("rb word%0d on done", k), rb_done_q[base+k], (k == NW-1));
      end
    end
`else
    check("rb word count (disabled)", rb_q.size() - base, 0);
`endif

    // Randomized loads against the reference model
    for (int r = 0; r < 20; r++) begin
      int gap;
      int rs;
      words = (NW*WW)'($urandom);
      gap   = int'($urandom_range(0, 4));
      rs    = int'($urandom_range(0, 15));
      repeat (int'($urandom_range(1, 3))) @(negedge prog_clk);
      snap   = chain;
      exp_rb = ref_rb(snap);
      base   = rb_q.size();
      run_load(words, gap, rs, bits, hs, en_cnt, stall, done_lat, late_ready, busy_bad);
      check($sformatf("rand%0d bits", r), bits, ref_bits(words));
      check($sformatf("rand%0d handshakes", r), hs, NW);
      check($sformatf("rand%0d clk_en count", r), en_cnt, CL);
      check($sformatf("rand%0d stall", r), stall, gap);
      check($sformatf("rand%0d done latency", r), done_lat, 1);
      check($sformatf("rand%0d chain", r), chain, ref_bits(words));
`ifdef CCFF_READBACK_EN
      check($sformatf("rand%0d rb count", r), rb_q.size() - base, NW);
      if (rb_q.size() - base == NW) begin
        for (int k = 0; k < NW; k++)
          check($sformatf("rand%0d rb word%0d", r, k), rb_q[base+k], exp_rb[(NW-k)*WW-1 -: WW]);
      end
`else
      check($sformatf("rand%0d rb count", r), rb_q.size() - base, 0);
`endif
    end

`ifndef CCFF_READBACK_EN
    check("rb_valid never asserted", rb_q.size(), 0);
    check("rb_data stays 0", rb_data, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Configuration-chain driver: the source end of the ccff_head/ccff_tail programming protocol used by every tile in the fabric.
- Accepts the bitstream as parallel words over a valid/ready interface and serializes it, MSB first, onto a tile chain's ccff_head.
- Produces the shift enable for the chain's prog_clk gate, counts exactly CHAIN_LEN bits, and signals completion.
- Optionally deserializes ccff_tail back into words, so the previous chain contents can be read back.

Parameters:
- CHAIN_LEN, 11, number of configuration flops in the driven chain (>=1).
- WORD_W, 8, bitstream word width (>=2).

Ports:
- prog_clk  input  1  programming clock; all state on rising edge.
- prog_reset_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a load of CHAIN_LEN bits.
- s_data  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- s_valid  input  1  s_data valid.
- s_ready  output  1  loader accepts s_data this cycle.
- ccff_head  output  1  serial data to the chain head.
- ccff_clk_en  output  1  chain shifts on the next prog_clk edge when high.
- ccff_tail  input  1  serial data from the chain tail.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse after the final bit is shifted.
- rb_data  output  WORD_W  readback word.
- rb_valid  output  1  one-cycle readback strobe.

Behaviour:
- Interface decision: one clock, prog_clk; reset is asynchronous and active-low, prog_reset_n.
- Reset values: all outputs 0, state IDLE, all counters 0.
- Reset asserted mid-load: immediate return to IDLE, ccff_clk_en=0, no done pulse. The partially loaded chain is left as is.

State machine:
- IDLE: s_ready=0 and s_valid is ignored. start -> LOAD; bits_left is loaded with CHAIN_LEN.
- LOAD: busy=1. Words are accepted and shifted out as described below.
  - When bits_left reaches 0 after a shift -> DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- start while busy is ignored. start and reset together: reset wins.

Word acceptance and shifting:
- Counters: bits_left has width $clog2(CHAIN_LEN+1); word_bits counts bits remaining in the shift register.
- s_ready=1 in LOAD when word_bits<=1 and bits_left > word_bits. This allows back-to-back words with no bubble.
- Handshake: on s_valid&&s_ready the word is loaded into the shift register. On the next cycle ccff_head = word[WORD_W-1] and ccff_clk_en=1.
- Each subsequent cycle advances one bit; ccff_clk_en stays high while bits remain in the register.
- Register empty and no word accepted (stall): ccff_clk_en=0, ccff_head holds its last value, bits_left is unchanged.
- ccff_clk_en is high for exactly CHAIN_LEN cycles per load in total.
- Final partial word: only its top (CHAIN_LEN mod WORD_W) MSBs are shifted; the remaining LSBs are discarded. s_ready stays 0 once all needed words are accepted.
- Latency: first ccff_clk_en one cycle after the first accepted word; done one cycle after the last ccff_clk_en cycle.

Optional Feature:
- Macro: CCFF_READBACK_EN.
- With the macro defined:
  - On every cycle with ccff_clk_en=1, ccff_tail is sampled (the pre-edge value) into a WORD_W deserializer, MSB first.
  - After WORD_W samples, rb_data is updated and rb_valid pulses for one cycle. There is no backpressure.
  - Final partial word: emitted on the cycle done pulses, left-justified, LSBs zero.
  - The first CHAIN_LEN samples are the chain's previous contents, with the tail-most flop first.
  - Reset clears the deserializer.
- Without the macro: the ports remain, rb_data=0 and rb_valid=0 constantly, and ccff_tail is unused.

Test Plan:
- CHAIN_LEN=10, WORD_W=4. Start, then words 0xA, 0x5, 0xC with s_valid held high -> ccff_head = 1,0,1,0,0,1,0,1,1,1 on 10 consecutive ccff_clk_en cycles. done fires on the cycle after the 10th. Exactly 3 handshakes occur; s_ready=0 afterwards.
- Same load, but s_valid drops for 3 cycles after the first word -> ccff_clk_en is low for those cycles, the bit sequence is unchanged, and the total ccff_clk_en count is 10.
- start pulsed again during LOAD, and s_valid asserted in IDLE -> no effect: no extra bits, no handshake, busy unchanged.
- prog_reset_n asserted low after 5 shifted bits -> outputs 0 asynchronously. No done pulse. A fresh start then loads a full 10 bits.
- Readback (CCFF_READBACK_EN), against a behavioural 10-flop chain preloaded with 0b1100110011 and the tail-most flop equal to bit 9 -> rb words 0xC, 0xC, then 0xC with the partial word on the done cycle. The chain then holds the new bitstream.
- Without CCFF_READBACK_EN, same stimulus -> rb_valid never asserts.
